// File: rtl/o_gate_sat_cnt.sv
// o_gate_sat_cnt -- W-bit saturating up-counter.
//
// Counts enabled cycles and sticks at all-ones instead of wrapping.
// Reset has priority over clear, and clear has priority over counting.
//
// Ports
//   clk    : clock, rising-edge active
//   rst    : synchronous active-high reset (count -> 0)
//   clr_i  : synchronous clear (count -> 0), ignored while rst=1
//   en_i   : count enable; adds one per edge unless saturated
//   cnt_o  : current count value
module o_gate_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  // Saturation value is derived here, so no shared constants are needed.
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/o_gate.sv
// o_gate -- two-input OR gate with registered output, rising-edge pulse,
// input-combination coverage flags and a saturating high-cycle counter.
//
// Ports
//   clk      : clock, rising-edge active
//   rst      : synchronous active-high reset (highest priority)
//   a, b     : OR operands
//   clr      : synchronous clear of seen and hi_count (below rst)
//   z        : combinational a|b, valid even with the clock stopped or in reset
//   z_q      : z delayed by one edge
//   z_rise   : high for the one cycle in which z_q has just gone 0->1
//   seen     : sticky flag per input combination, indexed by {a,b}
//   all_seen : AND of all four seen bits
//   hi_count : number of sampled edges at which z was 1, saturating
module o_gate #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             z,
  output logic             z_q,
  output logic             z_rise,
  output logic [3:0]       seen,
  output logic             all_seen,
  output logic [CNT_W-1:0] hi_count
);

  logic       zreg_q;
  logic       zreg_d;
  logic       rise_q;
  logic       rise_d;
  logic [3:0] seen_q;
  logic [3:0] seen_d;
  logic [1:0] sel;

  assign z   = a | b;
  assign sel = {a, b};

  always_comb begin
    zreg_d = z;
    // Uses the pre-edge z_q, so the pulse lines up with the edge where
    // z_q itself becomes 1.
    rise_d = z & ~zreg_q;
    seen_d = seen_q;
    if (clr) begin
      // The sample present during a clear is deliberately not recorded.
      seen_d = 4'b0000;
    end else begin
      seen_d[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zreg_q <= 1'b0;
      rise_q <= 1'b0;
      seen_q <= 4'b0000;
    end else begin
      zreg_q <= zreg_d;
      rise_q <= rise_d;
      seen_q <= seen_d;
    end
  end

  assign z_q      = zreg_q;
  assign z_rise   = rise_q;
  assign seen     = seen_q;
  assign all_seen = &seen_q;

  o_gate_sat_cnt #(
    .W (CNT_W)
  ) u_hi_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .en_i  (z),
    .cnt_o (hi_count)
  );

endmodule

// File: tb/tb_o_gate.sv
// tb_o_gate -- directed table-driven bench for o_gate.
// Two instances share stimulus: the default-width one and a CNT_W=2 one
// that exercises saturation.
module tb_o_gate;

  logic        clk;
  logic        rst;
  logic        a;
  logic        b;
  logic        clr;
  logic        z;
  logic        z_q;
  logic        z_rise;
  logic [3:0]  seen;
  logic        all_seen;
  logic [15:0] hi_count;
  logic        z2;
  logic        z_q2;
  logic        z_rise2;
  logic [3:0]  seen2;
  logic        all_seen2;
  logic [1:0]  hi_count2;

  int checks;
  int failures;

  o_gate dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
    .z(z), .z_q(z_q), .z_rise(z_rise), .seen(seen),
    .all_seen(all_seen), .hi_count(hi_count)
  );

  o_gate #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
    .z(z2), .z_q(z_q2), .z_rise(z_rise2), .seen(seen2),
    .all_seen(all_seen2), .hi_count(hi_count2)
  );

  typedef struct {
    logic        rst;
    logic        clr;
    logic        a;
    logic        b;
    logic        ez;      // z before the edge
    logic        ezq;     // values after the edge
    logic        erise;
    logic [3:0]  eseen;
    logic [15:0] ecnt;
    logic [1:0]  ecnt2;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Clock is driven only from here, so it stays idle during the combinational sweep.
  task automatic tick();
    #5 clk = 1'b1;
    #1;
  endtask

  task automatic fall();
    #4 clk = 1'b0;
  endtask

  task automatic add(input logic r, input logic c, input logic ai, input logic bi,
                     input logic ez, input logic ezq, input logic er,
                     input logic [3:0] es, input logic [15:0] ec, input logic [1:0] ec2);
    vec_t v;
    v.rst = r; v.clr = c; v.a = ai; v.b = bi; v.ez = ez; v.ezq = ezq;
    v.erise = er; v.eseen = es; v.ecnt = ec; v.ecnt2 = ec2;
    vecs.push_back(v);
  endtask

  task automatic edge_in(input logic r, input logic c, input logic ai, input logic bi);
    rst = r; clr = c; a = ai; b = bi;
    tick();
    fall();
  endtask

  initial begin
    logic [3:0] tt_a;
    logic [3:0] tt_b;
    logic [3:0] tt_z;
    checks = 0; failures = 0;
    clk = 1'b0; rst = 1'b1; clr = 1'b0; a = 1'b0; b = 1'b0;

    // Combinational sweep with clock idle and reset held.
    tt_a = 4'b1100; tt_b = 4'b1010; tt_z = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      a = tt_a[i]; b = tt_b[i];
      #1 chk("z_sweep_now", z, tt_z[i]);
      #99 chk("z_sweep_hold", z, tt_z[i]);
    end

    //   rst clr a b  z  zq rise seen     cnt cnt2
    add(1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    add(1, 0, 1, 1, 1, 0, 0, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 0);
    add(0, 0, 0, 1, 1, 1, 1, 4'b0011, 1, 1);
    add(0, 0, 0, 1, 1, 1, 0, 4'b0011, 2, 2);
    add(0, 0, 1, 0, 1, 1, 0, 4'b0111, 3, 3);
    add(0, 0, 1, 1, 1, 1, 0, 4'b1111, 4, 3);
    add(0, 0, 1, 0, 1, 1, 0, 4'b1111, 5, 3);
    add(0, 1, 1, 0, 1, 1, 0, 4'b0000, 0, 0);
    add(0, 0, 1, 0, 1, 1, 0, 4'b0100, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 4'b0101, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 4'b0101, 1, 1);
    add(0, 0, 1, 1, 1, 1, 1, 4'b1101, 2, 2);
    add(1, 1, 1, 1, 1, 0, 0, 4'b0000, 0, 0);
    add(0, 0, 1, 1, 1, 1, 1, 4'b1000, 1, 1);
    add(0, 0, 1, 1, 1, 1, 0, 4'b1000, 2, 2);
    add(0, 0, 1, 1, 1, 1, 0, 4'b1000, 3, 3);
    add(0, 0, 1, 1, 1, 1, 0, 4'b1000, 4, 3);
    add(0, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; clr = vecs[i].clr; a = vecs[i].a; b = vecs[i].b;
      #1 chk($sformatf("v%0d_z", i), z, vecs[i].ez);
      tick();
      chk($sformatf("v%0d_z_q", i), z_q, vecs[i].ezq);
      chk($sformatf("v%0d_z_rise", i), z_rise, vecs[i].erise);
      chk($sformatf("v%0d_seen", i), seen, vecs[i].eseen);
      chk($sformatf("v%0d_all_seen", i), all_seen, &vecs[i].eseen);
      chk($sformatf("v%0d_hi_count", i), hi_count, vecs[i].ecnt);
      chk($sformatf("v%0d_hi_count2", i), hi_count2, vecs[i].ecnt2);
      fall();
    end

    // Reset then all four combinations once each.
    edge_in(1, 0, 0, 0);
    edge_in(0, 0, 0, 0);
    edge_in(0, 0, 0, 1);
    edge_in(0, 0, 1, 0);
    edge_in(0, 0, 1, 1);
    chk("cover_seen", seen, 4'b1111);
    chk("cover_all_seen", all_seen, 1'b1);
    chk("cover_hi_count", hi_count, 16'd3);

    // Saturation of the 2-bit counter: hold a=1 for six edges.
    edge_in(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      edge_in(0, 0, 1, 0);
      chk($sformatf("sat_step%0d", i), hi_count2, (i < 3) ? (i + 1) : 3);
    end
    chk("sat_wide_count", hi_count, 16'd6);

    // A pulse on a between edges must affect only z, not the registers.
    edge_in(1, 0, 0, 0);
    edge_in(0, 0, 0, 0);
    #1 a = 1'b1;
    #1 chk("glitch_z_high", z, 1'b1);
    #1 a = 1'b0;
    #1 chk("glitch_z_low", z, 1'b0);
    tick();
    chk("glitch_z_q", z_q, 1'b0);
    chk("glitch_z_rise", z_rise, 1'b0);
    chk("glitch_hi_count", hi_count, 16'd0);
    chk("glitch_seen", seen, 4'b0001);
    fall();

    // z keeps following a|b while reset is held.
    rst = 1'b1; a = 1'b1; b = 1'b1;
    tick();
    chk("rst_z", z, 1'b1);
    chk("rst_z_q", z_q, 1'b0);
    fall();
    b = 1'b0; a = 1'b0;
    #1 chk("rst_z_follow", z, 1'b0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
